ir_decode_buf: RTL and testbench

- Instruction-register / decode stage that sits directly upstream of the immediate extender (`ext`).
- Accepts 32-bit MIPS instruction words over a valid/ready handshake and buffers up to two of them.
- Decodes each word at capture time into the `imm`, `EOp` and register-field values that `ext` and the register file consume.
- Presents the decoded entries in order over a second valid/ready handshake, with a synchronous flush and a retired-instruction counter.

---
 rtl/ir_decode_buf.sv | 76 +++++++
 tb/tb_ir_decode_buf.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/ir_decode_buf.sv
// ir_decode_buf: two-entry instruction buffer that decodes MIPS words at capture
// and presents imm/EOp/register fields of the head entry to the extender.
module ir_decode_buf #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [31:0]      instr,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       opcode,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [15:0]      imm,
  output logic [1:0]       EOp,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt
);
  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [1:0]  eop;
    logic        illegal;
  } entry_t;
  entry_t     mem [DEPTH];
  entry_t     dec;
  logic [1:0] count;
  logic       head, tail, push, pop;
  assign in_ready  = count != 2'(DEPTH);
  assign out_valid = count != 2'd0;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  always_comb begin
    dec.opcode  = instr[31:26];
    dec.rs      = instr[25:21];
    dec.rt      = instr[20:16];
    dec.rd      = instr[15:11];
    dec.imm     = instr[15:0];
    dec.eop     = instr[31:26] == 6'h04 ? 2'b11 :
                  instr[31:26] == 6'h0D ? 2'b01 :
                  instr[31:26] == 6'h0F ? 2'b10 : 2'b00;
    dec.illegal = !(instr[31:26] inside {6'h00, 6'h02, 6'h04, 6'h09, 6'h0D, 6'h0F, 6'h23, 6'h2B});
  end
  // Payload is only written, never reset; the empty-buffer gate below hides stale data.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[tail] <= dec;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      head      <= 1'b0;
      tail      <= 1'b0;
      instr_cnt <= '0;
    end else if (flush) begin
      count <= '0;
      head  <= 1'b0;
      tail  <= 1'b0;
    end else begin
      count <= count + {1'b0, push} - {1'b0, pop};
      if (push) tail <= ~tail;
      if (pop) begin
        head      <= ~head;
        instr_cnt <= instr_cnt + 1'b1;
      end
    end
  end
  assign {opcode, rs, rt, rd, imm, EOp, illegal} = out_valid ? mem[head] : '0;
endmodule

// File: tb/tb_ir_decode_buf.sv
// tb_ir_decode_buf: directed-vector bench for ir_decode_buf with hand-computed expectations.
module tb_ir_decode_buf;
  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] instr;
  logic        in_ready, out_valid, illegal;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm, instr_cnt;
  logic [1:0]  EOp;
  int          vectors = 0;
  int          miscompares = 0;

  ir_decode_buf #(.DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .instr(instr),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .EOp(EOp),
    .illegal(illegal), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_empty(input string tag, input logic [15:0] cnt);
    chk({tag, ".out_valid"}, 32'(out_valid), 0);
    chk({tag, ".in_ready"}, 32'(in_ready), 1);
    chk({tag, ".payload"}, {opcode, rs, rt, rd, illegal, EOp, 7'd0}, 0);
    chk({tag, ".imm"}, 32'(imm), 0);
    chk({tag, ".instr_cnt"}, 32'(instr_cnt), 32'(cnt));
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = '0;
    #3;
    chk_empty("reset", 16'd0);
    #9 rst_n = 1'b1;
    tick();
    // ori push, then pop
    in_valid = 1'b1; instr = 32'h3401FABC;
    tick();
    in_valid = 1'b0;
    chk("ori.out_valid", 32'(out_valid), 1);
    chk("ori.opcode", 32'(opcode), 32'h0D);
    chk("ori.rs", 32'(rs), 0);
    chk("ori.rt", 32'(rt), 1);
    chk("ori.rd", 32'(rd), 32'h1F);
    chk("ori.imm", 32'(imm), 32'hFABC);
    chk("ori.EOp", 32'(EOp), 1);
    chk("ori.illegal", 32'(illegal), 0);
    chk("ori.instr_cnt", 32'(instr_cnt), 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk_empty("ori_pop", 16'd1);
    // lui + beq fill the buffer; a third word is refused
    in_valid = 1'b1; instr = 32'h3C01FABC;
    tick();
    instr = 32'h1022FFFE;
    tick();
    chk("full.in_ready", 32'(in_ready), 0);
    chk("full.EOp", 32'(EOp), 2);
    chk("full.opcode", 32'(opcode), 32'h0F);
    instr = 32'hDEADBEEF;
    tick();
    chk("blocked.in_ready", 32'(in_ready), 0);
    chk("blocked.EOp", 32'(EOp), 2);
    chk("blocked.imm", 32'(imm), 32'hFABC);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("beq.EOp", 32'(EOp), 3);
    chk("beq.imm", 32'(imm), 32'hFFFE);
    chk("beq.rs", 32'(rs), 1);
    chk("beq.rt", 32'(rt), 2);
    chk("beq.opcode", 32'(opcode), 32'h04);
    chk("beq.in_ready", 32'(in_ready), 1);
    tick();
    out_ready = 1'b0;
    chk_empty("drain2", 16'd3);
    // streaming at count=1
    in_valid = 1'b1; instr = 32'h8C220004;
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("lw.in_ready", 32'(in_ready), 1);
      chk("lw.out_valid", 32'(out_valid), 1);
      chk("lw.opcode", 32'(opcode), 32'h23);
      chk("lw.imm", 32'(imm), 32'h0004);
      chk("lw.EOp", 32'(EOp), 0);
    end
    chk("lw.instr_cnt", 32'(instr_cnt), 7);
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    chk_empty("lw_drain", 16'd8);
    // illegal opcode still delivered
    in_valid = 1'b1; instr = 32'hFC000000;
    tick();
    in_valid = 1'b0;
    chk("ill.illegal", 32'(illegal), 1);
    chk("ill.EOp", 32'(EOp), 0);
    chk("ill.opcode", 32'(opcode), 32'h3F);
    chk("ill.out_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk_empty("ill_pop", 16'd9);
    // flush beats push and pop
    in_valid = 1'b1; instr = 32'h3401FABC;
    tick();
    instr = 32'h3C01FABC;
    tick();
    chk("preflush.in_ready", 32'(in_ready), 0);
    out_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk_empty("flush", 16'd9);
    tick();
    chk("flush_hold.out_valid", 32'(out_valid), 0);
    // asynchronous reset with a full buffer
    in_valid = 1'b1; instr = 32'h3401FABC;
    tick();
    tick();
    in_valid = 1'b0;
    chk("prerst.out_valid", 32'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk_empty("async_rst", 16'd0);
    #1 rst_n = 1'b1;
    // counter wrap over 65536 pops
    in_valid = 1'b1; instr = 32'h8C220004; out_ready = 1'b1;
    tick();
    chk("wrap.start", 32'(instr_cnt), 0);
    repeat (65535) @(posedge clk);
    #1;
    chk("wrap.max", 32'(instr_cnt), 32'hFFFF);
    tick();
    chk("wrap.zero", 32'(instr_cnt), 0);
    chk("wrap.out_valid", 32'(out_valid), 1);
    chk("wrap.in_ready", 32'(in_ready), 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
